// File: rtl/frame_fifo_reader.sv
// Pops {last,data} from a non-FWFT frame FIFO into a 2-deep skid buffer driving a valid/ready stream; over-long frames are truncated and drained.
// Read-to-valid latency 2 cycles, full rate under tready; statistics counters exist only with FRAME_FIFO_READER_STATS_EN.
module frame_fifo_reader #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_MAX_WORDS  = 380,
  parameter int P_CNT_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  output logic                    fifo_rd_o,
  input  logic [P_DATA_WIDTH:0]   fifo_data_i,
  input  logic                    fifo_empty_i,
  output logic [P_DATA_WIDTH-1:0] tdata_o,
  output logic                    tlast_o,
  output logic                    tvalid_o,
  input  logic                    tready_i,
  output logic                    frame_err_o,
  output logic [P_CNT_WIDTH-1:0]  frame_cnt_o,
  output logic [P_CNT_WIDTH-1:0]  err_cnt_o
);

  localparam int                  LP_WCNT_W    = $clog2(P_MAX_WORDS);
  localparam logic [LP_WCNT_W-1:0] LP_WCNT_LAST = LP_WCNT_W'(P_MAX_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [P_DATA_WIDTH:0] r_buf0;
  logic [P_DATA_WIDTH:0] r_buf1;
  logic [1:0]            r_cnt;
  logic                  r_inflt;
  logic [LP_WCNT_W-1:0]  r_wcnt;
  logic                  w_head_vld;
  logic                  w_head_last;
  logic                  w_force;
  logic                  w_acc;
  logic                  w_pop;
  logic [2:0]            w_occ;

  assign w_head_vld  = (r_cnt != 2'd0);
  assign w_head_last = r_buf0[P_DATA_WIDTH];
  assign tdata_o     = r_buf0[P_DATA_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    tvalid_o    = 1'b0;
    w_force     = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        tvalid_o = w_head_vld;
        if (tvalid_o && tready_i && !w_head_last) w_state_nxt = S_FRAME;
      end
      S_FRAME: begin
        tvalid_o = w_head_vld;
        // Forced last depends only on the head and wcnt, so it holds steady while stalled.
        w_force  = w_head_vld && (r_wcnt == LP_WCNT_LAST) && !w_head_last;
        if (tvalid_o && tready_i && (w_head_last || w_force))
          w_state_nxt = w_force ? S_DROP : S_IDLE;
      end
      S_DROP: begin
        w_pop = w_head_vld;
        if (w_head_vld && w_head_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_acc       = tvalid_o & tready_i;
    w_pop       = w_pop | w_acc;
    tlast_o     = tvalid_o & (w_head_last | w_force);
    frame_err_o = w_acc & w_force;
    w_occ       = {1'b0, r_cnt} + {2'b00, r_inflt} - {2'b00, w_pop};
    fifo_rd_o   = rstn_i & ~fifo_empty_i & (w_occ < 3'd2);
  end

  // Head is always r_buf0; r_buf1 shifts down on a pop.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_cnt   <= 2'd0;
      r_inflt <= 1'b0;
    end else begin
      r_inflt <= fifo_rd_o;
      case ({w_pop, r_inflt})
        2'b10: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd0) r_buf0 <= fifo_data_i;
          else               r_buf1 <= fifo_data_i;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_buf0 <= fifo_data_i;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= fifo_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i)    r_wcnt <= '0;
    else if (w_acc) r_wcnt <= tlast_o ? '0 : r_wcnt + LP_WCNT_W'(1);
  end

`ifdef FRAME_FIFO_READER_STATS_EN
  logic [P_CNT_WIDTH-1:0] r_frame_cnt;
  logic [P_CNT_WIDTH-1:0] r_err_cnt;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_acc && tlast_o) r_frame_cnt <= r_frame_cnt + P_CNT_WIDTH'(1);
      if (frame_err_o)      r_err_cnt   <= r_err_cnt + P_CNT_WIDTH'(1);
    end
  end

  assign frame_cnt_o = r_frame_cnt;
  assign err_cnt_o   = r_err_cnt;
`else
  assign frame_cnt_o = '0;
  assign err_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_frame_fifo_reader.sv
// Directed bench for frame_fifo_reader (max frame 4 words) with a behavioural FIFO and an expected-beat scoreboard.
module tb_frame_fifo_reader;

  localparam int DW   = 32;
  localparam int MAXW = 4;
  localparam int CW   = 32;
`ifdef FRAME_FIFO_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk_i;
  logic          rstn_i;
  logic          fifo_rd_o;
  logic [DW:0]   fifo_data_i;
  logic          fifo_empty_i;
  logic [DW-1:0] tdata_o;
  logic          tlast_o;
  logic          tvalid_o;
  logic          tready_i;
  logic          frame_err_o;
  logic [CW-1:0] frame_cnt_o;
  logic [CW-1:0] err_cnt_o;

  frame_fifo_reader #(.P_DATA_WIDTH(DW), .P_MAX_WORDS(MAXW), .P_CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .fifo_rd_o(fifo_rd_o), .fifo_data_i(fifo_data_i),
    .fifo_empty_i(fifo_empty_i), .tdata_o(tdata_o), .tlast_o(tlast_o), .tvalid_o(tvalid_o),
    .tready_i(tready_i), .frame_err_o(frame_err_o), .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [DW:0]   fq[$];
  logic [DW+1:0] exp_q[$];
  int            exp_frames = 0;
  int            exp_errs   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=1", tag, cond);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  // Loads a frame into the FIFO model and queues the beats the stream should carry.
  task automatic push_frame(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      fq.push_back({(i == n - 1), base + DW'(i)});
      fifo_empty_i = 1'b0;
      if (i < MAXW)
        exp_q.push_back({(n > MAXW) && (i == MAXW - 1), (i == n - 1) || (i == MAXW - 1), base + DW'(i)});
    end
    exp_frames++;
    if (n > MAXW) exp_errs++;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frame_cnt"}, frame_cnt_o, STATS ? 64'(exp_frames) : 64'd0);
    check({tag, "_err_cnt"}, err_cnt_o, STATS ? 64'(exp_errs) : 64'd0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k;
    k = 0;
    smp();
    while (!(exp_q.size() == 0 && fq.size() == 0 && !tvalid_o) && k < budget) begin
      smp();
      k++;
    end
    check_true({tag, "_drain"}, exp_q.size() == 0 && fq.size() == 0);
    repeat (4) smp();
  endtask

  // Upstream FIFO: one-cycle read latency.
  always @(posedge clk_i) begin
    if (fifo_rd_o && fq.size() > 0) fifo_data_i <= fq.pop_front();
    fifo_empty_i <= (fq.size() == 0);
  end

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat;
  logic          prev_last;
  logic [DW+1:0] e;
  int            rd_cnt = 0;
  int            acc_cnt = 0;
  int            occ_off = 0;
  bit            bound_en = 1'b0;
  int            occ;

  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (prev_stall) begin
        check("stall_dat", tdata_o, prev_dat);
        check("stall_last", tlast_o, prev_last);
      end
      if (fifo_rd_o) check_true("rd_while_empty", !fifo_empty_i);
      if (tvalid_o && tready_i) begin
        check_true("unexpected_beat", exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_dat", tdata_o, e[DW-1:0]);
          check("beat_last", tlast_o, e[DW]);
          check("beat_err", frame_err_o, e[DW+1]);
        end
      end else begin
        check("err_no_accept", frame_err_o, 0);
      end
      if (bound_en) begin
        occ = rd_cnt - acc_cnt - occ_off;
        check_true("occ_bound", occ <= 3);
        check_true("rd_overrun", !(fifo_rd_o && (occ - int'(tvalid_o && tready_i)) >= 2));
      end
    end
    if (fifo_rd_o) rd_cnt++;
    if (tvalid_o && tready_i) acc_cnt++;
    prev_stall = rstn_i && tvalid_o && !tready_i;
    prev_dat   = tdata_o;
    prev_last  = tlast_o;
  end

  initial begin
    int k;
    int total;
    int n;
    rstn_i       = 1'b0;
    tready_i     = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;

    // Reset with a non-empty FIFO, then first-read-to-valid latency.
    tick();
    push_frame(2, 32'hA000_0000);
    repeat (3) tick();
    smp();
    check("rst_rd", fifo_rd_o, 0);
    check("rst_tvalid", tvalid_o, 0);
    check("rst_tlast", tlast_o, 0);
    check("rst_tdata", tdata_o, 0);
    check("rst_err", frame_err_o, 0);
    check_counters("rst");
    tick();
    rstn_i = 1'b1;
    smp();
    check("lat_rd_n", fifo_rd_o, 1);
    check("lat_vld_n", tvalid_o, 0);
    smp();
    check("lat_vld_n1", tvalid_o, 0);
    smp();
    check("lat_vld_n2", tvalid_o, 1);
    tick();
    tready_i = 1'b1;
    wait_drain("first", 40);
    check_counters("first");

    // Three back-to-back 4-word frames at full rate.
    tick();
    push_frame(4, 32'h0000_1000);
    push_frame(4, 32'h0000_2000);
    push_frame(4, 32'h0000_3000);
    k = 0;
    smp();
    while (!tvalid_o && k < 10) begin
      smp();
      k++;
    end
    check_true("tput_start", tvalid_o);
    for (int i = 1; i < 12; i++) begin
      smp();
      check("tput_gap", tvalid_o, 1);
    end
    wait_drain("tput", 40);
    check_counters("tput");

    // Random backpressure over 64 words of short frames.
    tick();
    occ_off  = rd_cnt - acc_cnt;
    bound_en = 1'b1;
    total    = 0;
    while (total < 64) begin
      n = $urandom_range(1, MAXW);
      if (total + n > 64) n = 64 - total;
      push_frame(n, $urandom);
      total += n;
    end
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      tick();
      tready_i = 1'($urandom_range(0, 1));
      k++;
    end
    tick();
    tready_i = 1'b1;
    wait_drain("bp", 40);
    bound_en = 1'b0;
    check_counters("bp");

    // Over-long frame truncated and drained, followed by a short frame.
    tick();
    push_frame(7, 32'hB000_0000);
    push_frame(2, 32'hC000_0000);
    wait_drain("trunc", 60);
    check_counters("trunc");

    // Exact-length frame then a single-beat frame.
    tick();
    push_frame(MAXW, 32'hD000_0000);
    push_frame(1, 32'hD100_0000);
    wait_drain("exact", 40);
    check_counters("exact");

    // Reset after the second beat of a 5-word frame.
    tick();
    tready_i = 1'b0;
    push_frame(5, 32'hE000_0000);
    k = 0;
    smp();
    while (!tvalid_o && k < 10) begin
      smp();
      k++;
    end
    check_true("mid_start", tvalid_o);
    tick();
    tready_i = 1'b1;
    tick();
    tick();
    check_true("mid_two_beats", exp_q.size() == 2);
    rstn_i   = 1'b0;
    tready_i = 1'b0;
    fq.delete();
    fifo_empty_i = 1'b1;
    exp_q.delete();
    exp_frames = 0;
    exp_errs   = 0;
    smp();
    check("mid_rd_in_rst", fifo_rd_o, 0);
    tick();
    smp();
    check("mid_tvalid", tvalid_o, 0);
    check("mid_tlast", tlast_o, 0);
    check("mid_tdata", tdata_o, 0);
    check("mid_err", frame_err_o, 0);
    check_counters("mid_rst");
    tick();
    rstn_i   = 1'b1;
    tready_i = 1'b1;
    push_frame(5, 32'hF000_0000);
    wait_drain("post_rst", 40);
    check_counters("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
